// File: rtl/fmap_uart_uplink.sv
// Streams the conv-stage feature-map BRAM to the host over uart_basic as one framed packet.
// Optional trailing checksum byte: define FMAP_UPLINK_CHECKSUM_EN.
module fmap_uart_uplink #(
  parameter int          NUM_CH     = 3,
  parameter int          MAP_POS    = 36,
  parameter int          POS_W      = 6,
  parameter int          DATA_W     = 17,
  parameter int          RD_LAT     = 2,
  parameter logic [7:0]  HEADER     = 8'hA5,
  parameter int          BUSY_GUARD = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [2+POS_W-1:0]   rd_addr,
  input  logic [DATA_W-1:0]    rd_data,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy
);

  typedef enum logic [3:0] {
    IDLE, HDR, RD_REQ, RD_WAIT, TX_PULSE, TX_GUARD, TX_WAIT, NEXT, CSUM, FIN
  } state_t;

  typedef enum logic [1:0] {K_HDR, K_DATA, K_CSUM} kind_t;

  localparam logic [1:0]       CH_LAST  = 2'(NUM_CH - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(MAP_POS - 1);

  state_t           state_q, state_d;
  kind_t            kind_q;
  logic [7:0]       cnt_q;
  logic [1:0]       ch_q;
  logic [POS_W-1:0] pos_q;
  logic [1:0]       byte_idx_q;
  logic [15:0]      hi_q;
  logic [7:0]       tx_data_q;
  logic [23:0]      rd_ext;
  logic [7:0]       next_byte;
  logic [7:0]       payload_byte;
  logic             payload_load;
  logic             rd_wait_done;
  logic             guard_done;
  logic             last_word;

  assign rd_ext       = 24'(rd_data);
  assign rd_wait_done = (cnt_q == 8'(RD_LAT - 1));
  assign guard_done   = (cnt_q == 8'(BUSY_GUARD - 1));
  assign last_word    = (ch_q == CH_LAST) && (pos_q == POS_LAST);

  // Byte 0 goes straight from the BRAM output; only bytes 1 and 2 are kept in hi_q.
  always_comb begin
    next_byte    = (byte_idx_q == 2'd0) ? hi_q[7:0] : hi_q[15:8];
    payload_load = ((state_q == RD_WAIT) && rd_wait_done) ||
                   ((state_q == TX_WAIT) && !tx_busy && (kind_q == K_DATA) &&
                    (byte_idx_q != 2'd2));
    payload_byte = (state_q == RD_WAIT) ? rd_ext[7:0] : next_byte;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = HDR;
      // Holding here keeps a byte left running by an aborted frame from being overrun.
      HDR:      if (!tx_busy) state_d = TX_PULSE;
      RD_REQ:   state_d = RD_WAIT;
      RD_WAIT:  if (rd_wait_done) state_d = TX_PULSE;
      TX_PULSE: state_d = TX_GUARD;
      TX_GUARD: if (guard_done) state_d = TX_WAIT;
      TX_WAIT: begin
        if (!tx_busy) begin
          case (kind_q)
            K_HDR:   state_d = RD_REQ;
            K_DATA:  state_d = (byte_idx_q == 2'd2) ? NEXT : TX_PULSE;
            default: state_d = FIN;
          endcase
        end
      end
      NEXT: begin
        if (last_word) begin
`ifdef FMAP_UPLINK_CHECKSUM_EN
          state_d = CSUM;
`else
          state_d = FIN;
`endif
        end else begin
          state_d = RD_REQ;
        end
      end
`ifdef FMAP_UPLINK_CHECKSUM_EN
      CSUM:     state_d = TX_PULSE;
`endif
      FIN:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != IDLE) && (state_q != FIN);
    done     = (state_q == FIN);
    rd_en    = (state_q == RD_REQ);
    tx_start = (state_q == TX_PULSE);
    rd_addr  = {ch_q, pos_q};
    tx_data  = tx_data_q;
  end

`ifdef FMAP_UPLINK_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk) begin
    if (reset)                          csum_q <= '0;
    else if ((state_q == IDLE) && start) csum_q <= '0;
    else if (payload_load)              csum_q <= csum_q + payload_byte;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      kind_q     <= K_HDR;
      cnt_q      <= '0;
      ch_q       <= '0;
      pos_q      <= '0;
      byte_idx_q <= '0;
      hi_q       <= '0;
      tx_data_q  <= '0;
    end else begin
      cnt_q <= (state_d != state_q) ? '0 : cnt_q + 8'd1;
      if (payload_load) tx_data_q <= payload_byte;
      case (state_q)
        IDLE: begin
          if (start) begin
            kind_q     <= K_HDR;
            ch_q       <= '0;
            pos_q      <= '0;
            byte_idx_q <= '0;
          end
        end
        HDR: if (!tx_busy) tx_data_q <= HEADER;
        RD_WAIT: begin
          if (rd_wait_done) begin
            hi_q       <= rd_ext[23:8];
            byte_idx_q <= '0;
            kind_q     <= K_DATA;
          end
        end
        TX_WAIT: if (payload_load) byte_idx_q <= byte_idx_q + 2'd1;
        NEXT: begin
          if (pos_q == POS_LAST) begin
            pos_q <= '0;
            ch_q  <= last_word ? '0 : ch_q + 2'd1;
          end else begin
            pos_q <= pos_q + 1'b1;
          end
        end
`ifdef FMAP_UPLINK_CHECKSUM_EN
        CSUM: begin
          tx_data_q <= csum_q;
          kind_q    <= K_CSUM;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fmap_uart_uplink.sv
// Scoreboard bench for fmap_uart_uplink: BRAM model with 2-cycle latency and a uart_basic stub.
module tb_fmap_uart_uplink;
  localparam int NUM_CH  = 3;
  localparam int MAP_POS = 36;
  localparam int POS_W   = 6;
  localparam int DATA_W  = 17;
`ifdef FMAP_UPLINK_CHECKSUM_EN
  localparam int FRAME_LEN = 2 + NUM_CH * MAP_POS * 3;
`else
  localparam int FRAME_LEN = 1 + NUM_CH * MAP_POS * 3;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              busy, done, rd_en, tx_start, tx_busy;
  logic [POS_W+1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data = '0;
  logic [7:0]        tx_data;

  always #5 clk = ~clk;

  fmap_uart_uplink #(
    .NUM_CH(NUM_CH), .MAP_POS(MAP_POS), .POS_W(POS_W), .DATA_W(DATA_W),
    .RD_LAT(2), .HEADER(8'hA5), .BUSY_GUARD(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // BRAM: address registered on rd_en, data valid two cycles after the address.
  logic [DATA_W-1:0] mem [256];
  logic [DATA_W-1:0] bram_s1 = '0;
  always @(posedge clk) begin
    if (rd_en) bram_s1 <= mem[rd_addr];
    rd_data <= bram_s1;
  end

  // uart_basic stub: busy 10 cycles per byte, 500 for the byte at index stall_at.
  int fb = 0;
  int busy_left = 0;
  int stall_at = -1;
  always @(posedge clk) begin
    if (tx_start) busy_left <= (fb == stall_at + 1) ? 500 : 10;
    else if (busy_left > 0) busy_left <= busy_left - 1;
  end
  assign tx_busy = (busy_left > 0);

  logic [7:0] exp_q[$];
  logic [7:0] addr_q[$];
  int         done_cnt = 0;
  logic [7:0] prev_tx = '0;
  logic       prev_rst = 1'b1;

  always @(negedge clk) begin
    if (reset) begin
      fb = 0;
    end else begin
      if (tx_start) begin
        logic empty;
        check_eq("tx_while_busy", tx_busy, 0);
        empty = (exp_q.size() == 0);
        check_eq("sb_has_byte", empty, 0);
        if (!empty) check_eq("tx_byte", tx_data, exp_q.pop_front());
        fb++;
      end else if (!prev_rst && tx_data !== prev_tx) begin
        check_eq("tx_data_hold", tx_data, prev_tx);
      end
      if (rd_en) begin
        logic aempty;
        aempty = (addr_q.size() == 0);
        check_eq("sb_has_addr", aempty, 0);
        if (!aempty) check_eq("rd_addr", rd_addr, addr_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        check_eq("busy_at_done", busy, 0);
        check_eq("frame_len", fb, FRAME_LEN);
        check_eq("sb_drained", exp_q.size(), 0);
        fb = 0;
      end
    end
    prev_tx  = tx_data;
    prev_rst = reset;
  end

  task automatic fill_chpos();
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int c = 0; c < NUM_CH; c++)
      for (int p = 0; p < MAP_POS; p++) mem[c * (1 << POS_W) + p] = DATA_W'(c * (1 << POS_W) + p);
  endtask

  task automatic fill_corner();
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0] = 17'h1FFFF;
  endtask

  task automatic fill_ones();
    for (int i = 0; i < 256; i++) mem[i] = 17'h00001;
  endtask

  task automatic push_frame();
    logic [23:0] w;
`ifdef FMAP_UPLINK_CHECKSUM_EN
    logic [7:0] cs;
    cs = '0;
`endif
    exp_q.push_back(8'hA5);
    for (int c = 0; c < NUM_CH; c++) begin
      for (int p = 0; p < MAP_POS; p++) begin
        int a;
        a = c * (1 << POS_W) + p;
        addr_q.push_back(8'(a));
        w = 24'(mem[a]);
        for (int b = 0; b < 3; b++) begin
          exp_q.push_back(w[8*b +: 8]);
`ifdef FMAP_UPLINK_CHECKSUM_EN
          cs = cs + w[8*b +: 8];
`endif
        end
      end
    end
`ifdef FMAP_UPLINK_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_rd_en"}, rd_en, 0);
    check_eq({tag, "_rd_addr"}, rd_addr, 0);
    check_eq({tag, "_tx_start"}, tx_start, 0);
    check_eq({tag, "_tx_data"}, tx_data, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    check_eq("busy_before_start", busy, 0);
    start = 1'b1;
    @(posedge clk);
    #1 check_eq("busy_after_start", busy, 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int n;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_in_budget", done_cnt - d0, 1);
    repeat (40) @(negedge clk);
    check_eq("single_done", done_cnt - d0, 1);
    check_eq("busy_after_frame", busy, 0);
  endtask

  task automatic wait_byte(input int target);
    int n;
    n = 0;
    while (fb < target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_eq("reached_byte", fb >= target, 1);
  endtask

  task automatic run_frame();
    int d0;
    d0 = done_cnt;
    push_frame();
    pulse_start();
    wait_done(d0, 20000);
  endtask

  initial begin
    int d0;
    int n;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    // Start coincident with reset must be ignored.
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_idle_outputs("reset");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("post_reset");

    fill_chpos();
    run_frame();

    fill_corner();
    run_frame();

    stall_at = 7;
    fill_chpos();
    run_frame();
    stall_at = -1;

    // Second start mid-frame must be ignored.
    fill_chpos();
    d0 = done_cnt;
    push_frame();
    pulse_start();
    wait_byte(50);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(d0, 20000);

    // Reset mid-frame aborts without done.
    fill_chpos();
    d0 = done_cnt;
    push_frame();
    pulse_start();
    wait_byte(100);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(negedge clk);
    check_idle_outputs("abort");
    reset = 1'b0;
    repeat (50) @(negedge clk);
    check_eq("no_done_on_abort", done_cnt, d0);
    check_idle_outputs("abort_idle");
    n = 0;
    while (tx_busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("stub_idle", tx_busy, 0);
    run_frame();

    fill_ones();
    run_frame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
